// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: keeps one instruction-memory request in flight and presents
// each returned word to the IF/ID register. Responses to requests made obsolete by a redirect are dropped.
module if_fetch_unit #(
    parameter logic [63:0] RESET_PC     = 64'h0,
    parameter int          IMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        IF_IDen,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        IF_valid,
    output logic [63:0] IF_PCaddress,
    output logic [31:0] IF_Instruction,
    output logic        misalign_err,
    output logic        fetch_timeout,
    output logic [31:0] fetch_count
);

    localparam int WAIT_W = $clog2(IMEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(IMEM_TIMEOUT);

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t            state, state_next;
    logic              req_en;
    logic [63:0]       pc;
    logic [63:0]       stale_addr;
    logic [WAIT_W-1:0] wait_cnt;
    logic              rsp_take;

    assign rsp_take = imem_req && imem_rvalid;

    // NOTE: every flop in this block uses <=, so all processes see values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (redirect_valid) begin
                    state_next = (imem_req && !imem_rvalid) ? DRAIN : FETCH;
                end else if (rsp_take) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid || IF_IDen) begin
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    // NOTE: req_en keeps imem_req low through reset and the release cycle, so the first request
    // is raised by the first edge after rst_n goes high. Any response seen before then is ignored.
    always_comb begin
        imem_req  = req_en && (state != HOLD);
        imem_addr = (state == DRAIN) ? stale_addr : pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_en         <= 1'b0;
            pc             <= RESET_PC;
            stale_addr     <= 64'h0;
            IF_valid       <= 1'b0;
            IF_PCaddress   <= 64'h0;
            IF_Instruction <= 32'h0;
            misalign_err   <= 1'b0;
            fetch_count    <= 32'h0;
        end else begin
            req_en <= 1'b1;
            if (redirect_valid) begin
                pc             <= {redirect_pc[63:2], 2'b00};
                IF_valid       <= 1'b0;
                IF_Instruction <= 32'h0;
                if (redirect_pc[1:0] != 2'b00) begin
                    misalign_err <= 1'b1;
                end
                // In DRAIN the stale address is already captured and must not move.
                if (state == FETCH) begin
                    stale_addr <= pc;
                end
            end else begin
                case (state)
                    FETCH: begin
                        if (rsp_take) begin
                            IF_Instruction <= imem_rdata;
                            IF_PCaddress   <= pc;
                            IF_valid       <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (IF_IDen) begin
                            pc             <= pc + 64'd4;
                            IF_valid       <= 1'b0;
                            IF_Instruction <= 32'h0;
                            fetch_count    <= fetch_count + 32'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Wait counter restarts when a response retires the request; it saturates at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt      <= '0;
            fetch_timeout <= 1'b0;
        end else if (rsp_take) begin
            wait_cnt <= '0;
        end else if (imem_req && (wait_cnt != WAIT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_MAX - 1'b1) begin
                fetch_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios, then a random phase scored against
// an instruction-stream model (expected pc sequence, handoff count, stale-response drops).
module tb_if_fetch_unit;

    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        IF_IDen;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        IF_valid;
    logic [63:0] IF_PCaddress;
    logic [31:0] IF_Instruction;
    logic        misalign_err;
    logic        fetch_timeout;
    logic [31:0] fetch_count;

    int n_cmp = 0;
    int n_err = 0;

    // stream model state
    logic [63:0] exp_pc;
    logic [31:0] exp_cnt;
    bit          exp_valid, exp_mis, pend, stale, obs_req, acc;
    logic [63:0] lat_addr;
    int unsigned dly;

    if_fetch_unit #(.RESET_PC(RESET_PC), .IMEM_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .IF_IDen(IF_IDen),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .IF_valid(IF_valid), .IF_PCaddress(IF_PCaddress), .IF_Instruction(IF_Instruction),
        .misalign_err(misalign_err), .fetch_timeout(fetch_timeout), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, imem_req, 0);
        check({tag, "_valid"}, IF_valid, 0);
        check({tag, "_pcaddr"}, IF_PCaddress, 0);
        check({tag, "_instr"}, IF_Instruction, 0);
        check({tag, "_misalign"}, misalign_err, 0);
        check({tag, "_timeout"}, fetch_timeout, 0);
        check({tag, "_count"}, fetch_count, 0);
    endtask

    // Memory responder and random driver; runs at the negedge after the checks.
    task automatic drive_random();
        obs_req = imem_req;
        if (imem_req) begin
            if (!pend) begin
                pend = 1'b1;
                lat_addr = imem_addr;
                dly = $urandom_range(0, 3);
                check("rnd_new_req_addr", imem_addr, exp_pc);
            end else begin
                check("rnd_addr_stable", imem_addr, lat_addr);
            end
            if (dly == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(lat_addr);
            end else begin
                imem_rvalid = 1'b0;
                dly--;
            end
        end else begin
            imem_rvalid = ($urandom_range(0, 3) == 0);
            imem_rdata  = $urandom;
        end
        redirect_valid = ($urandom_range(0, 7) == 0);
        redirect_pc    = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1) redirect_pc[1:0] = 2'b00;
        IF_IDen = $urandom_range(0, 1);
    endtask

    initial begin
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0; IF_IDen = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");

        // release: request appears only after the first edge
        rst_n = 1'b1;
        #1 check("rel_req_low", imem_req, 0);
        step();
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, RESET_PC);

        // zero-latency stream: 0, 4 handed off, valid every second cycle
        IF_IDen = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("seq_addr", imem_addr, 64'(4 * i));
            imem_rvalid = 1'b1; imem_rdata = 32'h00000013;
            step();
            imem_rvalid = 1'b0;
            check("seq_valid", IF_valid, 1);
            check("seq_pc", IF_PCaddress, 64'(4 * i));
            check("seq_instr", IF_Instruction, 32'h13);
            check("seq_req_hold", imem_req, 0);
            step();
            check("seq_valid_low", IF_valid, 0);
            check("seq_count", fetch_count, 32'(i + 1));
        end

        // stall in HOLD at 0x8
        IF_IDen = 1'b0;
        check("stall_addr", imem_addr, 64'h8);
        imem_rvalid = 1'b1; imem_rdata = 32'h00000013;
        step();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", IF_valid, 1);
            check("stall_pc", IF_PCaddress, 64'h8);
            check("stall_instr", IF_Instruction, 32'h13);
            check("stall_req", imem_req, 0);
            check("stall_count", fetch_count, 2);
        end
        IF_IDen = 1'b1;
        step();
        check("unstall_addr", imem_addr, 64'hC);
        check("unstall_req", imem_req, 1);
        check("unstall_count", fetch_count, 3);
        check("unstall_instr", IF_Instruction, 0);

        // fetch 0xC, then redirect while 0x10 outstanding
        imem_rvalid = 1'b1;
        step();
        imem_rvalid = 1'b0;
        step();
        IF_IDen = 1'b0;
        check("pre_redir_addr", imem_addr, 64'h10);
        redirect_valid = 1'b1; redirect_pc = 64'h100;
        step();
        redirect_valid = 1'b0;
        check("drain_req", imem_req, 1);
        check("drain_addr", imem_addr, 64'h10);
        step(); step();
        check("drain_addr_hold", imem_addr, 64'h10);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
        step();
        imem_rvalid = 1'b0;
        check("drain_discard_valid", IF_valid, 0);
        check("drain_discard_instr", IF_Instruction, 0);
        check("after_drain_addr", imem_addr, 64'h100);
        check("after_drain_count", fetch_count, 4);

        // misaligned redirect in HOLD with IF_IDen=1
        imem_rvalid = 1'b1; imem_rdata = 32'h00100093;
        step();
        imem_rvalid = 1'b0;
        check("hold100_pc", IF_PCaddress, 64'h100);
        redirect_valid = 1'b1; redirect_pc = 64'h202; IF_IDen = 1'b1;
        step();
        redirect_valid = 1'b0; IF_IDen = 1'b0;
        check("mis_addr", imem_addr, 64'h200);
        check("mis_flag", misalign_err, 1);
        check("mis_count", fetch_count, 4);
        check("mis_valid", IF_valid, 0);

        // timeout: 16 waiting cycles, response at 20
        repeat (15) step();
        check("to_before", fetch_timeout, 0);
        step();
        check("to_set", fetch_timeout, 1);
        check("to_req", imem_req, 1);
        check("to_addr", imem_addr, 64'h200);
        repeat (4) step();
        imem_rvalid = 1'b1; imem_rdata = 32'hCAFE0001;
        step();
        imem_rvalid = 1'b0;
        check("to_late_valid", IF_valid, 1);
        check("to_late_pc", IF_PCaddress, 64'h200);
        check("to_late_instr", IF_Instruction, 32'hCAFE0001);
        check("to_sticky", fetch_timeout, 1);
        IF_IDen = 1'b1;
        step();
        IF_IDen = 1'b0;
        check("to_count", fetch_count, 5);

        // reset during DRAIN
        redirect_valid = 1'b1; redirect_pc = 64'h300;
        step();
        redirect_valid = 1'b0;
        check("pre_rst_drain_addr", imem_addr, 64'h204);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        imem_rvalid = 1'b0;
        check("rst_restart_req", imem_req, 1);
        check("rst_restart_addr", imem_addr, RESET_PC);
        check("rst_ignored_valid", IF_valid, 0);
        imem_rvalid = 1'b1; imem_rdata = 32'h00000013;
        step();
        imem_rvalid = 1'b0;
        check("rst_refetch_pc", IF_PCaddress, RESET_PC);
        check("rst_refetch_valid", IF_valid, 1);

        // random phase against the stream model
        rst_n = 1'b0;
        redirect_valid = 1'b0; IF_IDen = 1'b0; imem_rvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_pc = RESET_PC; exp_cnt = 32'h0; exp_valid = 1'b0; exp_mis = 1'b0;
        pend = 1'b0; stale = 1'b0; dly = 0; lat_addr = 64'h0;
        drive_random();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            acc = obs_req && imem_rvalid;
            if (redirect_valid) begin
                exp_pc = {redirect_pc[63:2], 2'b00};
                if (redirect_pc[1:0] != 2'b00) exp_mis = 1'b1;
                exp_valid = 1'b0;
                if (obs_req && !acc) stale = 1'b1;
            end else if (exp_valid && IF_IDen) begin
                exp_pc = exp_pc + 64'd4;
                exp_cnt = exp_cnt + 32'd1;
                exp_valid = 1'b0;
            end else if (acc && !stale) begin
                exp_valid = 1'b1;
            end
            if (acc) begin
                pend = 1'b0;
                stale = 1'b0;
            end
            @(negedge clk);
            check("rnd_valid", IF_valid, exp_valid);
            check("rnd_req", imem_req, !exp_valid);
            check("rnd_count", fetch_count, exp_cnt);
            check("rnd_misalign", misalign_err, exp_mis);
            check("rnd_timeout", fetch_timeout, 0);
            if (exp_valid) begin
                check("rnd_pc", IF_PCaddress, exp_pc);
                check("rnd_instr", IF_Instruction, mem_word(exp_pc));
            end else begin
                check("rnd_instr_zero", IF_Instruction, 0);
            end
            drive_random();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
